// File: rtl/wb_rr_arbiter.sv
// Four-master to one-slave Wishbone round-robin arbiter with registered one-hot grant.
// Optional stalled-strobe bus-error timeout is enabled by defining WB_ARB_TIMEOUT_EN.
module wb_rr_arbiter #(
  parameter int unsigned timeout_cycles = 255
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [127:0] m_adr_i,
  input  logic [127:0] m_dat_i,
  input  logic [15:0]  m_sel_i,
  input  logic [3:0]   m_we_i,
  input  logic [3:0]   m_cyc_i,
  input  logic [3:0]   m_stb_i,
  output logic [31:0]  m_dat_o,
  output logic [3:0]   m_ack_o,
  output logic [3:0]   m_err_o,
  output logic [31:0]  s_adr_o,
  output logic [31:0]  s_dat_o,
  output logic [3:0]   s_sel_o,
  output logic         s_we_o,
  output logic         s_cyc_o,
  output logic         s_stb_o,
  input  logic [31:0]  s_dat_i,
  input  logic         s_ack_i,
  output logic [3:0]   grant_o
);

  if (timeout_cycles < 2 || timeout_cycles > 65535) begin : g_bad_timeout
    $error("timeout_cycles must be in 2..65535");
  end

`ifdef WB_ARB_TIMEOUT_EN
  typedef enum logic [1:0] {StIdle, StBusy, StErr} state_e;
  localparam logic [15:0] TimeoutLast = 16'(timeout_cycles - 1);
  logic [15:0] cnt_q;
`else
  typedef enum logic [1:0] {StIdle, StBusy} state_e;
`endif

  state_e     state_q;
  logic [3:0] grant_q;
  logic [1:0] last_q;
  logic [1:0] pick;
  logic       busy;

  // Search from the master after the last winner, wrapping at 4.
  always_comb begin
    logic found;
    logic [1:0] cand;
    pick  = last_q;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cand = last_q + 2'(i);
      if (!found && m_cyc_i[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  // last_q doubles as the granted index while a grant is held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      grant_q <= '0;
      last_q  <= 2'd3;
`ifdef WB_ARB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (|m_cyc_i) begin
            state_q <= StBusy;
            grant_q <= 4'(1) << pick;
            last_q  <= pick;
`ifdef WB_ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
          end
        end
        StBusy: begin
          if (!m_cyc_i[last_q]) begin
            state_q <= StIdle;
            grant_q <= '0;
          end
`ifdef WB_ARB_TIMEOUT_EN
          else if (s_ack_i) begin
            cnt_q <= '0;
          end else if (m_stb_i[last_q]) begin
            cnt_q <= cnt_q + 16'd1;
            if (cnt_q == TimeoutLast) state_q <= StErr;
          end
`endif
        end
`ifdef WB_ARB_TIMEOUT_EN
        StErr: begin
          state_q <= StIdle;
          grant_q <= '0;
        end
`endif
        default: begin
          state_q <= StIdle;
          grant_q <= '0;
        end
      endcase
    end
  end

  assign busy    = (state_q == StBusy);
  assign grant_o = grant_q;
  assign m_dat_o = s_dat_i;

  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    m_ack_o = '0;
    if (busy) begin
      s_adr_o = m_adr_i[{last_q, 5'd0} +: 32];
      s_dat_o = m_dat_i[{last_q, 5'd0} +: 32];
      s_sel_o = m_sel_i[{last_q, 2'd0} +: 4];
      s_we_o  = m_we_i[last_q];
      s_cyc_o = m_cyc_i[last_q];
      s_stb_o = m_stb_i[last_q];
      m_ack_o = grant_q & {4{s_ack_i}};
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  assign m_err_o = (state_q == StErr) ? grant_q : 4'b0000;
`else
  assign m_err_o = 4'b0000;
`endif

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Bench for wb_rr_arbiter: per-cycle vector tables plus a scoreboard queue of expected outputs.
// Timeout rows run only when WB_ARB_TIMEOUT_EN is defined; otherwise a hung-slave hold test runs.
module tb_wb_rr_arbiter;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [127:0] m_adr_i;
  logic [127:0] m_dat_i;
  logic [15:0]  m_sel_i;
  logic [3:0]   m_we_i;
  logic [3:0]   m_cyc_i = '0;
  logic [3:0]   m_stb_i = '0;
  logic [31:0]  m_dat_o;
  logic [3:0]   m_ack_o;
  logic [3:0]   m_err_o;
  logic [31:0]  s_adr_o;
  logic [31:0]  s_dat_o;
  logic [3:0]   s_sel_o;
  logic         s_we_o;
  logic         s_cyc_o;
  logic         s_stb_o;
  logic [31:0]  s_dat_i = '0;
  logic         s_ack_i = 1'b0;
  logic [3:0]   grant_o;

  wb_rr_arbiter #(.timeout_cycles(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .m_adr_i (m_adr_i),
    .m_dat_i (m_dat_i),
    .m_sel_i (m_sel_i),
    .m_we_i  (m_we_i),
    .m_cyc_i (m_cyc_i),
    .m_stb_i (m_stb_i),
    .m_dat_o (m_dat_o),
    .m_ack_o (m_ack_o),
    .m_err_o (m_err_o),
    .s_adr_o (s_adr_o),
    .s_dat_o (s_dat_o),
    .s_sel_o (s_sel_o),
    .s_we_o  (s_we_o),
    .s_cyc_o (s_cyc_o),
    .s_stb_o (s_stb_o),
    .s_dat_i (s_dat_i),
    .s_ack_i (s_ack_i),
    .grant_o (grant_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] cyc;
    logic [3:0] stb;
    logic       ack;
    logic [3:0] grant;
    logic       scyc;
    logic [3:0] mack;
    logic [3:0] merr;
  } vec_t;

  typedef struct {
    logic [3:0]  grant;
    logic        scyc;
    logic        sstb;
    logic        swe;
    logic [3:0]  mack;
    logic [3:0]  merr;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] mdat;
  } exp_t;

  logic [31:0] adr_t [4];
  logic [31:0] dat_t [4];
  logic [3:0]  sel_t [4];
  logic [3:0]  we_t;
  vec_t        tbl [$];
  exp_t        sb [$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          row = 0;

  function automatic vec_t mk(logic rst, logic [3:0] cyc, logic [3:0] stb, logic ack,
                              logic [3:0] grant, logic scyc, logic [3:0] mack, logic [3:0] merr);
    vec_t v;
    v.rst = rst; v.cyc = cyc; v.stb = stb; v.ack = ack;
    v.grant = grant; v.scyc = scyc; v.mack = mack; v.merr = merr;
    return v;
  endfunction

  function automatic int oh_idx(logic [3:0] g);
    for (int i = 0; i < 4; i++) if (g[i]) return i;
    return 0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL row %0d %s: got %h want %h", row, nm, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue the expected outputs, compare at the falling edge.
  task automatic run_vec(input vec_t v);
    exp_t e;
    exp_t a;
    int   idx;
    logic busy;
    @(posedge clk);
    #1;
    reset   = v.rst;
    m_cyc_i = v.cyc;
    m_stb_i = v.stb;
    s_ack_i = v.ack;
    s_dat_i = $urandom;
    idx  = oh_idx(v.grant);
    busy = (v.grant != 4'b0000) && (v.merr == 4'b0000);
    e.grant = v.grant;
    e.scyc  = v.scyc;
    e.mack  = v.mack;
    e.merr  = v.merr;
    e.sstb  = busy ? v.stb[idx] : 1'b0;
    e.swe   = busy ? we_t[idx] : 1'b0;
    e.adr   = busy ? adr_t[idx] : 32'h0;
    e.dat   = busy ? dat_t[idx] : 32'h0;
    e.sel   = busy ? sel_t[idx] : 4'h0;
    e.mdat  = s_dat_i;
    sb.push_back(e);
    @(negedge clk);
    a = sb.pop_front();
    chk("grant_o", 32'(grant_o), 32'(a.grant));
    chk("s_cyc_o", 32'(s_cyc_o), 32'(a.scyc));
    chk("s_stb_o", 32'(s_stb_o), 32'(a.sstb));
    chk("s_we_o",  32'(s_we_o),  32'(a.swe));
    chk("m_ack_o", 32'(m_ack_o), 32'(a.mack));
    chk("m_err_o", 32'(m_err_o), 32'(a.merr));
    chk("s_adr_o", s_adr_o, a.adr);
    chk("s_dat_o", s_dat_o, a.dat);
    chk("s_sel_o", 32'(s_sel_o), 32'(a.sel));
    chk("m_dat_o", m_dat_o, a.mdat);
    row++;
  endtask

  task automatic run_tbl();
    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i]);
    tbl.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    we_t = 4'b1010;
    for (int n = 0; n < 4; n++) begin
      adr_t[n] = 32'hA000_0010 + 32'h0101_0101 * n;
      dat_t[n] = 32'h5000_0003 + 32'h0020_3040 * n;
      sel_t[n] = 4'(1) << n;
      m_adr_i[32*n +: 32] = adr_t[n];
      m_dat_i[32*n +: 32] = dat_t[n];
      m_sel_i[4*n +: 4]   = sel_t[n];
    end
    m_we_i = we_t;

    // Single request from m2, ack on the fourth cycle.
    tbl.push_back(mk(1, 4'b0000, 4'b0000, 0, 4'b0000, 0, 4'b0000, 4'b0000));
    tbl.push_back(mk(0, 4'b0100, 4'b0100, 0, 4'b0000, 0, 4'b0000, 4'b0000));
    tbl.push_back(mk(0, 4'b0100, 4'b0100, 0, 4'b0100, 1, 4'b0000, 4'b0000));
    tbl.push_back(mk(0, 4'b0100, 4'b0100, 0, 4'b0100, 1, 4'b0000, 4'b0000));
    tbl.push_back(mk(0, 4'b0100, 4'b0100, 1, 4'b0100, 1, 4'b0100, 4'b0000));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 4'b0100, 0, 4'b0000, 4'b0000));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 4'b0000, 4'b0000));
    // Four-way contention, one-cycle transfers: m0, m1, m2, m3, m0.
    tbl.push_back(mk(1, 4'b0000, 4'b0000, 0, 4'b0000, 0, 4'b0000, 4'b0000));
    tbl.push_back(mk(0, 4'b1111, 4'b1111, 0, 4'b0000, 0, 4'b0000, 4'b0000));
    tbl.push_back(mk(0, 4'b1111, 4'b1111, 1, 4'b0001, 1, 4'b0001, 4'b0000));
    tbl.push_back(mk(0, 4'b1110, 4'b1110, 0, 4'b0001, 0, 4'b0000, 4'b0000));
    tbl.push_back(mk(0, 4'b1111, 4'b1111, 0, 4'b0000, 0, 4'b0000, 4'b0000));
    tbl.push_back(mk(0, 4'b1111, 4'b1111, 1, 4'b0010, 1, 4'b0010, 4'b0000));
    tbl.push_back(mk(0, 4'b1101, 4'b1101, 0, 4'b0010, 0, 4'b0000, 4'b0000));
    tbl.push_back(mk(0, 4'b1111, 4'b1111, 0, 4'b0000, 0, 4'b0000, 4'b0000));
    tbl.push_back(mk(0, 4'b1111, 4'b1111, 1, 4'b0100, 1, 4'b0100, 4'b0000));
    tbl.push_back(mk(0, 4'b1011, 4'b1011, 0, 4'b0100, 0, 4'b0000, 4'b0000));
    tbl.push_back(mk(0, 4'b1111, 4'b1111, 0, 4'b0000, 0, 4'b0000, 4'b0000));
    tbl.push_back(mk(0, 4'b1111, 4'b1111, 1, 4'b1000, 1, 4'b1000, 4'b0000));
    tbl.push_back(mk(0, 4'b0111, 4'b0111, 0, 4'b1000, 0, 4'b0000, 4'b0000));
    tbl.push_back(mk(0, 4'b1111, 4'b1111, 0, 4'b0000, 0, 4'b0000, 4'b0000));
    tbl.push_back(mk(0, 4'b1111, 4'b1111, 1, 4'b0001, 1, 4'b0001, 4'b0000));
    tbl.push_back(mk(0, 4'b1110, 4'b1110, 0, 4'b0001, 0, 4'b0000, 4'b0000));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 4'b0000, 4'b0000));
    // m1 holds the grant across four strobes while m0 waits.
    tbl.push_back(mk(1, 4'b0000, 4'b0000, 0, 4'b0000, 0, 4'b0000, 4'b0000));
    tbl.push_back(mk(0, 4'b0010, 4'b0010, 0, 4'b0000, 0, 4'b0000, 4'b0000));
    tbl.push_back(mk(0, 4'b0011, 4'b0010, 1, 4'b0010, 1, 4'b0010, 4'b0000));
    tbl.push_back(mk(0, 4'b0011, 4'b0000, 0, 4'b0010, 1, 4'b0000, 4'b0000));
    tbl.push_back(mk(0, 4'b0011, 4'b0010, 1, 4'b0010, 1, 4'b0010, 4'b0000));
    tbl.push_back(mk(0, 4'b0011, 4'b0010, 1, 4'b0010, 1, 4'b0010, 4'b0000));
    tbl.push_back(mk(0, 4'b0011, 4'b0010, 1, 4'b0010, 1, 4'b0010, 4'b0000));
    tbl.push_back(mk(0, 4'b0001, 4'b0001, 0, 4'b0010, 0, 4'b0000, 4'b0000));
    tbl.push_back(mk(0, 4'b0001, 4'b0001, 0, 4'b0000, 0, 4'b0000, 4'b0000));
    tbl.push_back(mk(0, 4'b0001, 4'b0001, 0, 4'b0001, 1, 4'b0000, 4'b0000));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 4'b0001, 0, 4'b0000, 4'b0000));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 4'b0000, 4'b0000));
    run_tbl();

`ifdef WB_ARB_TIMEOUT_EN
    // m3 never acked: error eight cycles after its first strobe, then m0 wins.
    tbl.push_back(mk(1, 4'b0000, 4'b0000, 0, 4'b0000, 0, 4'b0000, 4'b0000));
    tbl.push_back(mk(0, 4'b1000, 4'b1000, 0, 4'b0000, 0, 4'b0000, 4'b0000));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(0, 4'b1000, 4'b1000, 0, 4'b1000, 1, 4'b0000, 4'b0000));
    tbl.push_back(mk(0, 4'b0101, 4'b0101, 0, 4'b1000, 0, 4'b0000, 4'b1000));
    tbl.push_back(mk(0, 4'b0101, 4'b0101, 0, 4'b0000, 0, 4'b0000, 4'b0000));
    tbl.push_back(mk(0, 4'b0101, 4'b0101, 0, 4'b0001, 1, 4'b0000, 4'b0000));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 4'b0001, 0, 4'b0000, 4'b0000));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 4'b0000, 4'b0000));
    // Ack on the timeout cycle wins over the error.
    tbl.push_back(mk(0, 4'b1000, 4'b1000, 0, 4'b0000, 0, 4'b0000, 4'b0000));
    for (int i = 0; i < 7; i++)
      tbl.push_back(mk(0, 4'b1000, 4'b1000, 0, 4'b1000, 1, 4'b0000, 4'b0000));
    tbl.push_back(mk(0, 4'b1000, 4'b1000, 1, 4'b1000, 1, 4'b1000, 4'b0000));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 4'b1000, 0, 4'b0000, 4'b0000));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 4'b0000, 4'b0000));
    run_tbl();
`else
    // Hung slave: grant held, no error, for 1000 cycles.
    tbl.push_back(mk(1, 4'b0000, 4'b0000, 0, 4'b0000, 0, 4'b0000, 4'b0000));
    tbl.push_back(mk(0, 4'b0100, 4'b0100, 0, 4'b0000, 0, 4'b0000, 4'b0000));
    for (int i = 0; i < 1000; i++)
      tbl.push_back(mk(0, 4'b0100, 4'b0100, 0, 4'b0100, 1, 4'b0000, 4'b0000));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 4'b0100, 0, 4'b0000, 4'b0000));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 4'b0000, 4'b0000));
    run_tbl();
`endif

    // Reset in the middle of an m0 transfer, with the slave acking at that moment.
    tbl.push_back(mk(1, 4'b0000, 4'b0000, 0, 4'b0000, 0, 4'b0000, 4'b0000));
    tbl.push_back(mk(0, 4'b0011, 4'b0011, 0, 4'b0000, 0, 4'b0000, 4'b0000));
    tbl.push_back(mk(0, 4'b0011, 4'b0011, 0, 4'b0001, 1, 4'b0000, 4'b0000));
    run_tbl();
    @(posedge clk);
    #1;
    s_ack_i = 1'b1;
    #1;
    chk("busy before reset s_cyc_o", 32'(s_cyc_o), 32'd1);
    chk("busy before reset m_ack_o", 32'(m_ack_o), 32'h1);
    #1;
    reset = 1'b1;
    #1;
    chk("async reset grant_o", 32'(grant_o), 32'h0);
    chk("async reset s_cyc_o", 32'(s_cyc_o), 32'h0);
    chk("async reset s_stb_o", 32'(s_stb_o), 32'h0);
    chk("async reset m_ack_o", 32'(m_ack_o), 32'h0);
    chk("async reset m_err_o", 32'(m_err_o), 32'h0);
    @(posedge clk);
    #1;
    reset   = 1'b0;
    s_ack_i = 1'b0;
    // Released into a tie between m0 and m1; m0 must win.
    tbl.push_back(mk(0, 4'b0011, 4'b0011, 0, 4'b0001, 1, 4'b0000, 4'b0000));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 4'b0001, 0, 4'b0000, 4'b0000));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 4'b0000, 4'b0000));
    run_tbl();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_rr_arbiter.md
WB_RR_ARBITER -- requirements
Module: wb_rr_arbiter

Interface
REQ-001 The block SHALL have parameter timeout_cycles, default 255, meaning the number of stalled strobe cycles before a bus error (range 2..65535).
REQ-002 The block SHALL have port clk, input, 1, meaning the single system clock; all state is on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, meaning the asynchronous, active-high reset.
REQ-004 The block SHALL have ports m_adr_i, m_dat_i, input, 128 each, meaning the address and write data of masters 0..3, 32 bits per master, master n at [32n+31:32n].
REQ-005 The block SHALL have port m_sel_i, input, 16, meaning the byte selects, 4 bits per master.
REQ-006 The block SHALL have ports m_we_i, m_cyc_i and m_stb_i, input, 4 each, meaning the per-master write enable, cycle and strobe.
REQ-007 The block SHALL have port m_dat_o, output, 32, meaning the read data broadcast to all masters.
REQ-008 The block SHALL have ports m_ack_o and m_err_o, output, 4 each, meaning the per-master acknowledge and bus error.
REQ-009 The block SHALL have ports s_adr_o and s_dat_o, output, 32 each; s_sel_o, output, 4; and s_we_o, s_cyc_o, s_stb_o, output, 1 each; meaning the single slave port.
REQ-010 The block SHALL have ports s_dat_i, input, 32, and s_ack_i, input, 1, meaning the slave read data and acknowledge.
REQ-011 The block SHALL have port grant_o, output, 4, meaning the one-hot registered grant (0 when idle).

Function
REQ-012 The FSM SHALL have states IDLE, BUSY and ERR.
REQ-013 In IDLE with any m_cyc_i high, the block SHALL grant the first requesting master found searching from (last+1) mod 4 upward, then enter BUSY on the next edge.
REQ-014 Grant latency SHALL be exactly 1 cycle: a request sampled at edge N drives s_cyc_o at N+1, never earlier.
REQ-015 The pointer "last" SHALL update to the granted index at each grant.
REQ-016 In BUSY, s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o and s_stb_o SHALL be driven combinationally from the granted master.
REQ-017 In BUSY, s_ack_i SHALL be routed combinationally only to the granted master's m_ack_o bit; all other ack and err bits SHALL be 0.
REQ-018 m_dat_o SHALL equal s_dat_i at all times.
REQ-019 Grant SHALL be held while the granted m_cyc_i stays high, covering back-to-back and burst strobes; non-granted requests wait.
REQ-020 When the granted m_cyc_i is sampled low in BUSY, the block SHALL return to IDLE; at least one idle cycle SHALL separate consecutive grants.
REQ-021 A master dropping m_cyc_i in the same cycle that another raises it SHALL give no grant that cycle; arbitration occurs in the following IDLE cycle.
REQ-022 Outside BUSY, s_cyc_o, s_stb_o and s_we_o SHALL be 0, and s_adr_o, s_dat_o and s_sel_o SHALL be 0.

Reset
REQ-023 Asserting reset SHALL immediately and asynchronously force IDLE, grant_o=0, last=3 (so master 0 wins the first contention), timeout counter 0, and all slave controls, m_ack_o and m_err_o to 0.
REQ-024 Reset mid-transfer SHALL abort the transfer without any ack or err pulse being generated.

Configuration
REQ-025 When WB_ARB_TIMEOUT_EN is defined, a 16-bit counter SHALL clear on grant and on s_ack_i, and SHALL increment in BUSY while s_stb_o=1 and s_ack_i=0.
REQ-026 With WB_ARB_TIMEOUT_EN defined, when the counter reaches timeout_cycles-1 with no ack, the block SHALL enter ERR for exactly one cycle.
REQ-027 In ERR, the block SHALL pulse the granted m_err_o bit, hold s_cyc_o and s_stb_o at 0, then go to IDLE with last unchanged, so the next requester wins.
REQ-028 An s_ack_i arriving in the same cycle as the timeout SHALL win: ack is delivered, no err is raised and the counter clears.
REQ-029 Without WB_ARB_TIMEOUT_EN, the counter and ERR state SHALL be absent, m_err_o SHALL be tied to 0, and a hung slave SHALL hold the grant indefinitely.

Verification
REQ-030 Single request: after reset, m2 raises cyc/stb at cycle 0 and the slave acks at cycle 3 -> s_cyc_o=1 from cycle 1, grant_o=4'b0100, m_ack_o=4'b0100 at cycle 3 only.
REQ-031 Contention: all four masters request continuously with 1-cycle transfers -> grant order m0, m1, m2, m3, m0, with one idle cycle between grants.
REQ-032 Hold: m1 granted and issuing 4 strobes under one cyc while m0 requests -> m0 not granted until cycle after m1 drops cyc.
REQ-033 Timeout (macro on, timeout_cycles=8): slave never acks m3 -> m_err_o=4'b1000 for one cycle 8 cycles after first strobe, then s_cyc_o=0; with an ack at that same cycle, ack and no err.
REQ-034 Reset mid-transfer: assert reset while m0 is in BUSY -> s_cyc_o=0 and grant_o=0 in the same cycle, no ack or err; after release, m0 wins a tie with m1.
REQ-035 Macro off: slave never acks -> m_err_o stays 0 for 1000 cycles and grant stays held.
